dmem_bytewise: RTL and testbench
================================

// Module: dmem_bytewise
// PURPOSE
//  Parametrised data memory for the MIPS datapath. Successor to the word-only data memory.
//  Adds byte/half/word loads and stores (sb/sh/sw, lb/lbu/lh/lhu/lw), little-endian lanes,
//  misalignment and out-of-range detection, a sticky error flag, and a post-reset clear sequencer.
//  Sits between the ALU result (address) / register file rt (store data) and the writeback mux.
// PARAMETERS
//  DEPTH           256  number of 32-bit words (power of 2, >=4); AW = $clog2(DEPTH)
//  CLEAR_ON_RESET  1    1: zero every word after reset (busy for DEPTH cycles); 0: skip clear
// PORTS
//  clk        in   1   clock, all state changes on posedge
//  rst_n      in   1   reset, asynchronous, active-low
//  a          in   32  byte address (ALU result)
//  wd         in   32  store data, right-aligned (sb uses wd[7:0], sh uses wd[15:0])
//  we         in   1   store request
//  re         in   1   load request
//  size       in   2   00 byte, 01 half, 10 word, 11 illegal
//  uns        in   1   1: zero-extend byte/half loads (lbu/lhu); 0: sign-extend
//  rd         out  32  load data, extended to 32 bits
//  rd_valid   out  1   rd carries a legal load result
//  busy       out  1   clear sequence running; all accesses ignored
//  misalign   out  1   current access misaligned or size==11 (combinational)
//  oob        out  1   current access outside DEPTH words (combinational)
//  err        out  1   sticky: any illegal access accepted since reset
// BEHAVIOUR
//  - Word index = a[AW+1:2]; lane = a[1:0]. oob = |a[31:AW+2] & (we|re).
//  - misalign = (we|re) & (size==11 | (size==01 & a[0]) | (size==10 & a[1:0]!=0)).
//  - legal = !busy & !misalign & !oob. Illegal stores never modify memory.
//  - Store at posedge when we & legal: byte -> lane a[1:0] <= wd[7:0]; half -> lanes
//    {a[1],1},{a[1],0} <= wd[15:0]; word -> whole word. Other lanes preserved.
//  - Load: select lane(s) per size/a[1:0], then sign- or zero-extend per uns; word ignores uns.
//  - rd = 0 and rd_valid = 0 whenever not (re & legal).
//  - we & re same cycle, same word: rd returns pre-write contents (read-before-write).
//  - err: reset 0; set at posedge when (we|re) & !busy & (misalign|oob); cleared only by reset.
//  - Clear FSM, states CLEAR, READY. rst_n low -> state = CLEAR (READY if CLEAR_ON_RESET=0),
//    ptr = 0, err = 0, busy = 1 (0 if CLEAR_ON_RESET=0). In CLEAR each cycle mem[ptr] <= 0, ptr++;
//    on the cycle ptr==DEPTH-1 is written -> READY. busy = (state==CLEAR); clear = exactly DEPTH cycles.
//  - Reset asserted mid-clear restarts clear from ptr=0. Requests during busy: ignored, no err.
//  - Reset values: rd=0, rd_valid=0, err=0, busy=1 (CLEAR_ON_RESET=1) else 0; misalign/oob
//    follow inputs.
// CONFIGURATION
//  DMEM_SYNC_READ_EN defined: rd/rd_valid registered; load data appears the cycle after the
//   request (1-cycle latency), reset to 0; rd is 0 and rd_valid 0 the cycle after a non-legal
//   or absent load; same-word write in request cycle -> old data.
//  Undefined: asynchronous read, rd/rd_valid combinational in request cycle (single-cycle core).
// STRUCTURE
//  Package dmem_pkg: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, clear-FSM state encodings.
//  Sub-module dmem_load_align (combinational): {word, lane, size, uns} -> extended rd.
//  Store lane merge, checks, FSM, error flag and array stay in dmem_bytewise.
// TESTING (DEPTH=32, CLEAR_ON_RESET=1; run both with and without DMEM_SYNC_READ_EN)
//  1 Reset release -> busy=1 for exactly 32 cycles, then 0; lw at 0x7C -> 0x00000000.
//  2 sw 0x11223344 @0x10; sb 0xAA @0x11; lw @0x10 -> 0x1122AA44; lb @0x11 -> 0xFFFFFFAA;
//    lbu @0x11 -> 0x000000AA.
//  3 sh 0x8001 @0x12 over 0x1122AA44 -> lw 0x8001AA44; lh @0x12 -> 0xFFFF8001; lhu -> 0x00008001.
//  4 sw @0x13 -> misalign=1, memory unchanged, err=1 next cycle; lw @0x80 -> oob=1, rd_valid=0.
//  5 sw 0xDEADBEEF and lw @0x20 same cycle (prior 0) -> rd=0x00000000; next lw -> 0xDEADBEEF.
//  6 rst_n low at clear cycle 10, release -> busy again 32 cycles, err=0; sw during busy no effect.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-addressable data memory: access sizes,
// clear-sequencer states and the store lane-enable helper.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // Little-endian byte enables for a store of the given size at lane offset.
  function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: laneMask = 4'b0001 << lane;
      SZ_HALF: laneMask = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: laneMask = 4'b1111;
      default: laneMask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane selection and sign/zero extension for byte, half and word loads.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign byteSel = word_i[{lane_i, 3'b000} +: 8];
  assign halfSel = lane_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    data_o = '0;
    case (size_i)
      SZ_BYTE: data_o = {{24{byteSel[7] & ~uns_i}}, byteSel};
      SZ_HALF: data_o = {{16{halfSel[15] & ~uns_i}}, halfSel};
      SZ_WORD: data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_bytewise.sv
// Byte-addressable data memory with sb/sh/sw stores, extended loads, access checks,
// sticky error flag and post-reset clear. DMEM_SYNC_READ_EN selects registered read data.
module dmem_bytewise
  import dmem_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] rd,
  output logic        rd_valid,
  output logic        busy,
  output logic        misalign,
  output logic        oob,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam clr_state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  logic [31:0]   mem_q [DEPTH];
  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          err_q;

  logic          accessReq, legal, storeEn, loadEn, clearWr;
  logic [AW-1:0] wordIdx;
  logic [31:0]   oldWord, newWord, wdRep, alignedData;
  logic [3:0]    byteEn;

  assign accessReq = we | re;
  assign wordIdx   = a[AW+1:2];
  assign oob       = (|a[31:AW+2]) & accessReq;
  assign misalign  = accessReq & ((size == SZ_ILLEGAL) |
                                  ((size == SZ_HALF) & a[0]) |
                                  ((size == SZ_WORD) & (a[1:0] != 2'b00)));
  assign busy      = (state_q == CLEAR);
  assign legal     = !busy & !misalign & !oob;
  assign storeEn   = we & legal;
  assign loadEn    = re & legal;
  assign err       = err_q;

  // Store data arrives right-aligned; replicate it so every lane sees its slice.
  assign oldWord = mem_q[wordIdx];
  assign wdRep   = (size == SZ_BYTE) ? {4{wd[7:0]}} :
                   (size == SZ_HALF) ? {2{wd[15:0]}} : wd;
  assign byteEn  = laneMask(size, a[1:0]);

  always_comb begin
    newWord = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (byteEn[i]) newWord[8*i +: 8] = wdRep[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accessReq & !busy & (misalign | oob)) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clearWr = 1'b0;
    case (state_q)
      CLEAR: begin
        clearWr = 1'b1;
        ptr_d   = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH - 1)) state_d = READY;
      end
      default: ;
    endcase
  end

  // The array has no reset; the clear sequencer zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (clearWr) begin
      mem_q[ptr_q] <= '0;
    end else if (storeEn) begin
      mem_q[wordIdx] <= newWord;
    end
  end

  dmem_load_align u_align (
    .word_i (oldWord),
    .lane_i (a[1:0]),
    .size_i (size),
    .uns_i  (uns),
    .data_o (alignedData)
  );

`ifdef DMEM_SYNC_READ_EN
  logic [31:0] rd_q;
  logic        rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_q       <= loadEn ? alignedData : '0;
      rd_valid_q <= loadEn;
    end
  end

  assign rd       = rd_q;
  assign rd_valid = rd_valid_q;
`else
  assign rd       = loadEn ? alignedData : '0;
  assign rd_valid = loadEn;
`endif

endmodule

// File: tb/tb_dmem_bytewise.sv
// Self-checking bench for dmem_bytewise (DEPTH=32): directed scenarios plus random
// traffic against a byte-array reference model; works with or without DMEM_SYNC_READ_EN.
module tb_dmem_bytewise;

  localparam int DEPTH  = 32;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, wd = '0;
  logic        we = 1'b0, re = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] rd;
  logic        rd_valid, busy, misalign, oob, err;

  logic [7:0]  modelMem [NBYTES];
  int          clearLeft = 0;
  logic        errModel = 1'b0;
  int          nCompared = 0;
  int          nMismatched = 0;

  dmem_bytewise #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .wd       (wd),
    .we       (we),
    .re       (re),
    .size     (size),
    .uns      (uns),
    .rd       (rd),
    .rd_valid (rd_valid),
    .busy     (busy),
    .misalign (misalign),
    .oob      (oob),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Little-endian read of the byte array, extended with plain arithmetic.
  function automatic logic [31:0] modelLoad(input int base, input logic [1:0] sz, input logic u);
    logic [31:0] v;
    case (sz)
      2'b00: begin
        v = 32'(modelMem[base]);
        if (!u && v >= 32'd128) v = v - 32'd256;
      end
      2'b01: begin
        v = 32'(modelMem[base]) + 32'(modelMem[base+1]) * 32'd256;
        if (!u && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = 32'(modelMem[base]) + 32'(modelMem[base+1]) * 32'd256 +
                   32'(modelMem[base+2]) * 32'd65536 + 32'(modelMem[base+3]) * 32'd16777216;
    endcase
    return v;
  endfunction

  task automatic modelStore(input int base, input logic [31:0] data, input logic [1:0] sz);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) modelMem[base+i] = 8'(data >> (8 * i));
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic w,
                               input logic r, input logic [1:0] sz, input logic u);
    logic expMis, expOob, expBusy, expLegal;
    logic [31:0] expRd;
    int base;
    a = addr; wd = data; we = w; re = r; size = sz; uns = u;
    expBusy  = (clearLeft > 0);
    expMis   = (w || r) && (sz == 2'b11 || (sz == 2'b01 && addr % 2 != 0) ||
                            (sz == 2'b10 && addr % 4 != 0));
    expOob   = (w || r) && (addr >= NBYTES);
    expLegal = !expBusy && !expMis && !expOob;
    base     = int'(addr % NBYTES);
    expRd    = (r && expLegal) ? modelLoad(base, sz, u) : 32'h0;
    @(negedge clk);
    checkOutput("busy", 32'(busy), 32'(expBusy));
    checkOutput("misalign", 32'(misalign), 32'(expMis));
    checkOutput("oob", 32'(oob), 32'(expOob));
`ifndef DMEM_SYNC_READ_EN
    checkOutput("rd", rd, expRd);
    checkOutput("rd_valid", 32'(rd_valid), 32'(r && expLegal));
`endif
    @(posedge clk);
    #1;
    if (w && expLegal) modelStore(base, data, sz);
    if ((w || r) && !expBusy && (expMis || expOob)) errModel = 1'b1;
    if (clearLeft > 0) clearLeft--;
`ifdef DMEM_SYNC_READ_EN
    checkOutput("rd", rd, expRd);
    checkOutput("rd_valid", 32'(rd_valid), 32'(r && expLegal));
`endif
    checkOutput("err", 32'(err), 32'(errModel));
  endtask

  task automatic idleCycle();
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
  endtask

  task automatic doReset();
    we = 1'b0; re = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_rd", rd, 32'h0);
    checkOutput("reset_rd_valid", 32'(rd_valid), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clearLeft = DEPTH;
    errModel = 1'b0;
    for (int i = 0; i < NBYTES; i++) modelMem[i] = 8'h00;
  endtask

  initial begin
    logic [31:0] addr, data;
    logic [1:0]  sz;
    logic        w, r, u;

    $display("[TB] start");
    @(posedge clk);
    #1;
    doReset();
    while (clearLeft > 0) idleCycle();
    idleCycle();
    applyStimulus(32'h7C, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);

    applyStimulus(32'h10, 32'h11223344, 1'b1, 1'b0, 2'b10, 1'b0);
    applyStimulus(32'h11, 32'h000000AA, 1'b1, 1'b0, 2'b00, 1'b0);
    applyStimulus(32'h10, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    applyStimulus(32'h11, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0);
    applyStimulus(32'h11, 32'h0, 1'b0, 1'b1, 2'b00, 1'b1);

    applyStimulus(32'h12, 32'h00008001, 1'b1, 1'b0, 2'b01, 1'b0);
    applyStimulus(32'h10, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    applyStimulus(32'h12, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0);
    applyStimulus(32'h12, 32'h0, 1'b0, 1'b1, 2'b01, 1'b1);

    applyStimulus(32'h20, 32'hDEADBEEF, 1'b1, 1'b1, 2'b10, 1'b0);
    applyStimulus(32'h20, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);

    applyStimulus(32'h13, 32'hCAFEF00D, 1'b1, 1'b0, 2'b10, 1'b0);
    applyStimulus(32'h10, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    applyStimulus(32'h80, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);

    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      data = $urandom;
      if ($urandom_range(0, 15) == 0) addr = $urandom | 32'h80;
      else addr = 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b10) addr = addr & ~32'h3;
        else if (sz == 2'b01) addr = addr & ~32'h1;
      end
      applyStimulus(addr, data, w, r, sz, u);
    end

    doReset();
    for (int i = 0; i < 10; i++) idleCycle();
    doReset();
    for (int i = 0; i < 20; i++) idleCycle();
    applyStimulus(32'h08, 32'h5A5A5A5A, 1'b1, 1'b0, 2'b10, 1'b0);
    applyStimulus(32'h09, 32'h0, 1'b1, 1'b1, 2'b11, 1'b0);
    while (clearLeft > 0) idleCycle();
    applyStimulus(32'h08, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);

    for (int n = 0; n < 100; n++) begin
      sz   = 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, NBYTES - 1));
      if (sz == 2'b10) addr = addr & ~32'h3;
      else if (sz == 2'b01) addr = addr & ~32'h1;
      applyStimulus(addr, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
                    1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
